// File: rtl/booth_pkg.sv
// Shared definitions for the Booth partial-product stage: digit codes,
// skid-buffer state encoding and partial-product width derivation.
package booth_pkg;

  // Booth digit codes as {sign, mag2, mag1}
  localparam logic [2:0] DIG_ZERO = 3'b000;
  localparam logic [2:0] DIG_P1   = 3'b001;
  localparam logic [2:0] DIG_P2   = 3'b010;
  localparam logic [2:0] DIG_M1   = 3'b101;
  localparam logic [2:0] DIG_M2   = 3'b110;

  // Occupancy of the output register + skid entry
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Partial products need two extra bits: one for the x2 shift, one for sign
  function automatic int ppw_of(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/booth_pp_row.sv
// Single Booth digit: selects 0 / M / 2M, then inverts for negative digits.
// Build option BOOTH_PP_FOLD_NEG_EN folds the +1 correction into the
// partial product (true two's complement) and drives neg_o to 0.
module booth_pp_row
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PPW   = ppw_of(WIDTH)
) (
  input  logic [2:0]              code_i,
  input  logic signed [WIDTH-1:0] mcand_i,
  output logic [PPW-1:0]          pp_o,
  output logic                    neg_o,
  output logic                    illegal_o
);

  logic [PPW-1:0] sext;
  logic [PPW-1:0] mag;
  logic           negate;

  assign sext = {{(PPW-WIDTH){mcand_i[WIDTH-1]}}, mcand_i};

  // Magnitude select and conditional negation; illegal and sign-only codes give 0
  always_comb begin
    mag       = '0;
    negate    = 1'b0;
    illegal_o = code_i[1] & code_i[0];
    case (code_i)
      DIG_P1:   mag = sext;
      DIG_P2:   mag = sext << 1;
      DIG_M1: begin
        mag    = sext;
        negate = 1'b1;
      end
      DIG_M2: begin
        mag    = sext << 1;
        negate = 1'b1;
      end
      DIG_ZERO: mag = '0;
      default:  mag = '0;
    endcase
`ifdef BOOTH_PP_FOLD_NEG_EN
    pp_o  = negate ? (~mag + 1'b1) : mag;
    neg_o = 1'b0;
`else
    pp_o  = negate ? ~mag : mag;
    neg_o = negate;
`endif
  end

endmodule

// File: rtl/booth_pp_gen.sv
// Booth partial-product generator: forms NDIG partial products from the
// encoder's sign/magnitude digits and buffers them in a registered stage
// with a 2-entry skid buffer (output register + skid entry).
// Build option BOOTH_PP_FOLD_NEG_EN: fold +1 corrections into pp, neg=0.
//
// Handshake: a beat transfers on a side when valid and ready are both high
// at a rising clk edge. in_ready is a flop (no combinational path from
// out_ready); pp/neg hold while out_valid=1 and out_ready=0.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int NDIG  = WIDTH / 2,
  localparam int PPW   = ppw_of(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] mcand,
  input  logic [NDIG-1:0]         enc2,
  input  logic [NDIG-1:0]         enc1,
  input  logic [NDIG-1:0]         enc0,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NDIG*PPW-1:0]     pp,
  output logic [NDIG-1:0]         neg,
  output logic                    illegal_enc
);

  localparam int EW = NDIG*PPW + NDIG;

  logic [NDIG*PPW-1:0] pp_new;
  logic [NDIG-1:0]     neg_new;
  logic [NDIG-1:0]     ill_new;
  logic [EW-1:0]       entry_new;

  skid_state_e   state_q, state_d;
  logic [EW-1:0] out_q, out_d;
  logic [EW-1:0] skid_q, skid_d;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          illegal_q, illegal_d;
  logic          accept;
  logic          pop;

  for (genvar i = 0; i < NDIG; i++) begin : g_row
    booth_pp_row #(.WIDTH(WIDTH), .PPW(PPW)) u_row (
      .code_i    ({enc2[i], enc1[i], enc0[i]}),
      .mcand_i   (mcand),
      .pp_o      (pp_new[i*PPW +: PPW]),
      .neg_o     (neg_new[i]),
      .illegal_o (ill_new[i])
    );
  end

  assign entry_new = {pp_new, neg_new};
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid_q & out_ready;

  // Skid-buffer next state: output register first, skid entry absorbs a stall
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    skid_d    = skid_q;
    illegal_d = illegal_q | (accept & (|ill_new));
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = entry_new;
          state_d = HALF;
        end
      end
      HALF: begin
        if (accept && pop) begin
          out_d = entry_new;
        end else if (accept) begin
          skid_d  = entry_new;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          out_d   = skid_q;
          state_d = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and data registers; flags are registered decodes of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      out_q       <= out_d;
      skid_q      <= skid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign pp          = out_q[EW-1:NDIG];
  assign neg         = out_q[NDIG-1:0];
  assign illegal_enc = illegal_q;

endmodule

// File: doc/booth_pp_gen.md
Name: booth_pp_gen

Overview:
- Stage directly downstream of the radix-4 modified Booth encoder.
- Takes the encoder's per-digit sign/magnitude outputs plus the signed multiplicand and forms the NDIG partial products for the Wallace tree.
- Registered stage with a 2-entry skid buffer and valid/ready handshake on both sides.
- Full throughput of one operand set per cycle; order is preserved.

Parameters:
- WIDTH, 16, multiplicand width in bits; must be even.
- NDIG, WIDTH/2, number of Booth digits. Derived; not overridden.
- PPW, WIDTH+2, width of each partial product.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  stage can accept data; registered.
- mcand  in  WIDTH  signed two's-complement multiplicand.
- enc2  in  NDIG  per-digit sign bit (1 = negative).
- enc1  in  NDIG  per-digit magnitude-2 select.
- enc0  in  NDIG  per-digit magnitude-1 select.
- out_valid  out  1  partial products valid.
- out_ready  in  1  Wallace tree accepts.
- pp  out  NDIG*PPW  partial products; digit i occupies bits [i*PPW +: PPW]; weight 2^(2i) is applied by the consumer.
- neg  out  NDIG  per-digit +1 correction bits, added at weight 2^(2i).
- illegal_enc  out  1  sticky flag: an illegal digit code was accepted.

Behaviour:
- Reset (async, rst_n=0): state EMPTY; in_ready=1; out_valid=0; pp=0; neg=0; illegal_enc=0. Reset mid-operation discards all buffered entries.
- Per-digit arithmetic:
  - m = sext(mcand, PPW) when enc0[i]=1.
  - m = sext(mcand, PPW)<<1 when enc1[i]=1.
  - m = 0 otherwise.
  - pp_i = enc2[i] ? ~m : m.
  - neg[i] = enc2[i] & (enc0[i] | enc1[i]).
  - Result: pp_i + neg[i] = digit*mcand exactly.
- Sign with zero magnitude (enc2=1, enc1=enc0=0): pp_i=0, neg[i]=0. This is a valid code and does not set the flag.
- Illegal code (enc1[i]=enc0[i]=1): digit treated as zero (pp_i=0, neg[i]=0). illegal_enc sets on acceptance and stays set until reset.
- Transfer occurs when valid&ready are both high in the same cycle.
- Latency: data accepted in cycle N appears on pp/neg with out_valid=1 in cycle N+1.
- FSM states:
  - EMPTY: out_valid=0, in_ready=1.
  - HALF: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0; skid entry holds the second item.
- Transitions:
  - EMPTY --accept--> HALF.
  - HALF --accept & !pop--> FULL.
  - HALF --pop & !accept--> EMPTY.
  - HALF --accept & pop--> HALF; the output register loads the new item.
  - FULL --pop--> HALF; the skid entry moves to the output register.
- in_ready is a registered version of "state != FULL", so upstream sees no combinational path from out_ready.
- Stability: while out_valid=1 and out_ready=0, pp and neg hold stable.
- in_valid is ignored while in_ready=0.
- Arithmetic is computed before buffering. Both the skid and output registers store NDIG*PPW+NDIG bits.

Optional Feature:
- Macro: BOOTH_PP_FOLD_NEG_EN.
- Defined: pp_i is true two's complement (~m+1 when negative, computed internally); neg output driven constant 0.
- Undefined: one's-complement pp plus the neg correction bits, as described above.
- Handshake, latency and illegal_enc behaviour are identical in both builds.

Decomposition:
- Package booth_pkg holds:
  - Digit-code localparams: DIG_ZERO=3'b000, DIG_P1=3'b001, DIG_P2=3'b010, DIG_M1=3'b101, DIG_M2=3'b110.
  - Skid FSM state encoding: EMPTY/HALF/FULL.
  - PPW derivation.
- One sub-module, booth_pp_row: combinational single-digit selector/inverter taking {enc2,enc1,enc0}[i] and mcand, producing pp_i, neg_i and illegal_i. It is instantiated NDIG times in a generate loop.

Test Plan:
- mcand=16'h0003, all digits +2 (enc1=8'hFF, enc2=enc0=0) -> next cycle every pp_i=18'h00006, neg=0, out_valid=1.
- mcand=16'h0003, digit0 -1 (enc2=1, enc0=1), others 0:
  - Unfolded build -> pp_0=18'h3FFFC, neg=8'h01.
  - Folded build -> pp_0=18'h3FFFD, neg=0.
- mcand=16'h8000, digit7 -2 -> pp_7=~(18'h30000)=18'h0FFFF with neg[7]=1; sum = +65536.
- out_ready=0, three back-to-back in_valid beats A,B,C:
  - A and B are accepted; in_ready=0 one cycle after B; C is held.
  - out_ready=1 -> outputs A, B, C in order on consecutive cycles; no loss or duplication.
- Digit3 enc1=enc0=1 -> pp_3=0, neg[3]=0, illegal_enc=1 and remaining 1 over later legal traffic until rst_n pulse.
- State FULL, rst_n asserted asynchronously mid-cycle -> out_valid=0 and in_ready=1 immediately; after release, old data is never emitted.
